// File: rtl/wb_merge_unit_if.sv
// Producer-side result bus for wb_merge_unit: per-source valid/ready plus packed
// {rd, data, fmt, off} fields, flattened as NUM_SRC slices.
interface wb_merge_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 3
);
  localparam int OFF_W = $clog2(XLEN / 8);

  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic [NUM_SRC*5-1:0]     src_rd;
  logic [NUM_SRC*XLEN-1:0]  src_data;
  logic [NUM_SRC*3-1:0]     src_fmt;
  logic [NUM_SRC*OFF_W-1:0] src_off;

  modport master (
    output src_valid, src_rd, src_data, src_fmt, src_off,
    input  src_ready
  );

  modport slave (
    input  src_valid, src_rd, src_data, src_fmt, src_off,
    output src_ready
  );
endinterface

// File: rtl/wb_merge_unit.sv
// Writeback merge: per-source FIFOs drained round-robin onto the single regfile
// write port, with load byte/half/word extraction and x0 write suppression.
module wb_merge_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load_buffers,
  wb_merge_unit_if.slave   src,
  output logic [XLEN-1:0]  regfile_in,
  output logic [4:0]       dest,
  output logic             load_regfile,
  output logic             busy
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int RRW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SHW   = OFF_W + 3;

  typedef enum logic [2:0] {
    FMT_RAW  = 3'd0,
    FMT_LB   = 3'd1,
    FMT_LBU  = 3'd2,
    FMT_LH   = 3'd3,
    FMT_LHU  = 3'd4,
    FMT_LW   = 3'd5,
    FMT_LWU  = 3'd6,
    FMT_RAW7 = 3'd7
  } fmt_e;

  logic [4:0]       rd_mem   [NUM_SRC][FIFO_DEPTH];
  logic [XLEN-1:0]  data_mem [NUM_SRC][FIFO_DEPTH];
  fmt_e             fmt_mem  [NUM_SRC][FIFO_DEPTH];
  logic [OFF_W-1:0] off_mem  [NUM_SRC][FIFO_DEPTH];

  logic [PW-1:0]      wr_ptr [NUM_SRC];
  logic [PW-1:0]      rd_ptr [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] push;

  logic [RRW-1:0] rr_ptr;
  logic [RRW-1:0] win;
  logic [RRW-1:0] rr_next;
  logic           found;
  logic           pop;
  int unsigned    idx;

  logic [4:0]       h_rd;
  logic [XLEN-1:0]  h_data;
  fmt_e             h_fmt;
  logic [OFF_W-1:0] h_off;
  logic [SHW-1:0]   sh_b;
  logic [SHW-1:0]   sh_h;
  logic [SHW-1:0]   sh_w;
  logic [7:0]       b8;
  logic [15:0]      h16;
  logic [31:0]      w32;
  logic [XLEN-1:0]  ext;

  // Full/empty from the extra pointer MSB; ready uses registered state only.
  always_comb begin
    empty         = '0;
    full          = '0;
    push          = '0;
    src.src_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      empty[i]         = (wr_ptr[i] == rd_ptr[i]);
      full[i]          = (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]) &&
                         (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      src.src_ready[i] = ~full[i];
      push[i]          = src.src_valid[i] && ~full[i] && !rst && !flush;
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_SRC;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        win   = RRW'(idx);
      end
    end
    pop     = found && load_buffers && !flush && !rst;
    rr_next = (32'(win) == 32'(NUM_SRC - 1)) ? '0 : win + 1'b1;
  end

  // Alignment masks drop the misaligned low offset bits for half/word lanes.
  always_comb begin
    h_rd   = rd_mem[win][rd_ptr[win][AW-1:0]];
    h_data = data_mem[win][rd_ptr[win][AW-1:0]];
    h_fmt  = fmt_mem[win][rd_ptr[win][AW-1:0]];
    h_off  = off_mem[win][rd_ptr[win][AW-1:0]];
    sh_b   = {h_off, 3'b000};
    sh_h   = sh_b & ~SHW'(15);
    sh_w   = sh_b & ~SHW'(31);
    b8     = 8'(h_data >> sh_b);
    h16    = 16'(h_data >> sh_h);
    w32    = 32'(h_data >> sh_w);
    ext    = h_data;
    case (h_fmt)
      FMT_LB:  ext = XLEN'($signed(b8));
      FMT_LBU: ext = XLEN'(b8);
      FMT_LH:  ext = XLEN'($signed(h16));
      FMT_LHU: ext = XLEN'(h16);
      FMT_LW:  ext = XLEN'($signed(w32));
      FMT_LWU: ext = XLEN'(w32);
      default: ext = h_data;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        rd_mem[i][wr_ptr[i][AW-1:0]]   <= src.src_rd[i*5 +: 5];
        data_mem[i][wr_ptr[i][AW-1:0]] <= src.src_data[i*XLEN +: XLEN];
        fmt_mem[i][wr_ptr[i][AW-1:0]]  <= fmt_e'(src.src_fmt[i*3 +: 3]);
        off_mem[i][wr_ptr[i][AW-1:0]]  <= src.src_off[i*OFF_W +: OFF_W];
      end
    end
  end

  // Flush shares the reset path except that the arbitration pointer survives.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      regfile_in   <= '0;
      dest         <= '0;
      load_regfile <= 1'b0;
      if (rst) rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
      end
      if (pop) begin
        rd_ptr[win]  <= rd_ptr[win] + 1'b1;
        rr_ptr       <= rr_next;
        dest         <= h_rd;
        regfile_in   <= (h_rd != 5'd0) ? ext : '0;
        load_regfile <= (h_rd != 5'd0);
      end else begin
        load_regfile <= 1'b0;
      end
    end
  end

  assign busy = (|(~empty)) || load_regfile;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit: extraction vector table plus hand-built
// multi-cycle sequences checked against a small FIFO/round-robin model.
module tb_wb_merge_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        load_buffers;
  logic [31:0] regfile_in;
  logic [4:0]  dest;
  logic        load_regfile;
  logic        busy;

  int tests = 0;
  int fails = 0;

  wb_merge_unit_if #(.XLEN(32), .NUM_SRC(3)) bus ();

  wb_merge_unit #(.XLEN(32), .NUM_SRC(3), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .load_buffers (load_buffers),
    .src          (bus.slave),
    .regfile_in   (regfile_in),
    .dest         (dest),
    .load_regfile (load_regfile),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  fmt;
    logic [1:0]  off;
    logic [31:0] exp_data;
    logic        exp_load;
  } vec_t;

  vec_t vt [14];

  // Reference model: per-source circular queues and a round-robin pointer.
  logic [31:0] mq [3][4];
  int          mh [3];
  int          mc [3];
  int          sq [3];
  int          rr;
  logic [31:0] e_data;
  logic [4:0]  e_dest;
  logic        e_load;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    flush         = 1'b0;
    load_buffers  = 1'b0;
    bus.src_valid = '0;
    bus.src_rd    = '0;
    bus.src_data  = '0;
    bus.src_fmt   = '0;
    bus.src_off   = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0;
      mc[i] = 0;
      sq[i] = 0;
    end
    rr     = 0;
    e_data = '0;
    e_dest = '0;
    e_load = 1'b0;
  endtask

  task automatic step(input logic [2:0] v, input logic lb, input logic fl);
    logic [2:0]  er;
    logic [31:0] d [3];
    logic        eb;
    int          w;
    int          ix;
    for (int i = 0; i < 3; i++) begin
      er[i] = (mc[i] < 4);
      d[i]  = {8'(i), 24'(sq[i])};
    end
    chk("src_ready", 64'(bus.src_ready), 64'(er));
    bus.src_valid = v;
    for (int i = 0; i < 3; i++) begin
      bus.src_rd[i*5 +: 5]    = 5'(i + 1);
      bus.src_data[i*32 +: 32] = d[i];
    end
    bus.src_fmt  = '0;
    bus.src_off  = '0;
    load_buffers = lb;
    flush        = fl;
    w = -1;
    for (int k = 0; k < 3; k++) begin
      ix = (rr + k) % 3;
      if (w < 0 && mc[ix] > 0) w = ix;
    end
    if (fl) begin
      for (int i = 0; i < 3; i++) begin
        mc[i] = 0;
        mh[i] = 0;
      end
      e_load = 1'b0;
      e_dest = '0;
      e_data = '0;
    end else begin
      if (lb && w >= 0) begin
        e_data = mq[w][mh[w]];
        mh[w]  = (mh[w] + 1) % 4;
        mc[w]  = mc[w] - 1;
        e_dest = 5'(w + 1);
        e_load = 1'b1;
        rr     = (w + 1) % 3;
      end else begin
        e_load = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i] && er[i]) begin
          mq[i][(mh[i] + mc[i]) % 4] = d[i];
          mc[i] = mc[i] + 1;
          sq[i] = sq[i] + 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.src_valid = '0;
    flush         = 1'b0;
    eb = e_load || (mc[0] > 0) || (mc[1] > 0) || (mc[2] > 0);
    chk("load_regfile", 64'(load_regfile), 64'(e_load));
    chk("dest", 64'(dest), 64'(e_dest));
    chk("regfile_in", 64'(regfile_in), 64'(e_data));
    chk("busy", 64'(busy), 64'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{5'd5,  32'h1234_5678, 3'd0, 2'd0, 32'h1234_5678, 1'b1};
    vt[1]  = '{5'd1,  32'hF0E0_8001, 3'd1, 2'd1, 32'hFFFF_FF80, 1'b1};
    vt[2]  = '{5'd2,  32'hF0E0_8001, 3'd2, 2'd1, 32'h0000_0080, 1'b1};
    vt[3]  = '{5'd3,  32'hF0E0_8001, 3'd3, 2'd2, 32'hFFFF_F0E0, 1'b1};
    vt[4]  = '{5'd4,  32'hF0E0_8001, 3'd4, 2'd0, 32'h0000_8001, 1'b1};
    vt[5]  = '{5'd6,  32'hF0E0_8001, 3'd5, 2'd0, 32'hF0E0_8001, 1'b1};
    vt[6]  = '{5'd7,  32'hF0E0_8001, 3'd6, 2'd2, 32'hF0E0_8001, 1'b1};
    vt[7]  = '{5'd8,  32'hF0E0_8001, 3'd7, 2'd3, 32'hF0E0_8001, 1'b1};
    vt[8]  = '{5'd0,  32'hDEAD_BEEF, 3'd0, 2'd0, 32'h0000_0000, 1'b0};
    vt[9]  = '{5'd9,  32'hF0E0_8001, 3'd1, 2'd3, 32'hFFFF_FFF0, 1'b1};
    vt[10] = '{5'd10, 32'hF0E0_8001, 3'd2, 2'd2, 32'h0000_00E0, 1'b1};
    vt[11] = '{5'd11, 32'hF0E0_8001, 3'd3, 2'd3, 32'hFFFF_F0E0, 1'b1};
    vt[12] = '{5'd12, 32'hF0E0_8001, 3'd4, 2'd1, 32'h0000_8001, 1'b1};
    vt[13] = '{5'd31, 32'h0000_007F, 3'd1, 2'd0, 32'h0000_007F, 1'b1};

    do_reset();
    chk("rst load_regfile", 64'(load_regfile), 64'd0);
    chk("rst dest", 64'(dest), 64'd0);
    chk("rst regfile_in", 64'(regfile_in), 64'd0);
    chk("rst src_ready", 64'(bus.src_ready), 64'h7);
    chk("rst busy", 64'(busy), 64'd0);

    // Single-entry vectors on source 0: push at one edge, written at the next.
    for (int n = 0; n < 14; n++) begin
      bus.src_valid       = 3'b001;
      bus.src_rd[4:0]     = vt[n].rd;
      bus.src_data[31:0]  = vt[n].data;
      bus.src_fmt[2:0]    = vt[n].fmt;
      bus.src_off[1:0]    = vt[n].off;
      load_buffers        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.src_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d load_regfile", n), 64'(load_regfile), 64'(vt[n].exp_load));
      chk($sformatf("vec%0d dest", n), 64'(dest), 64'(vt[n].rd));
      chk($sformatf("vec%0d regfile_in", n), 64'(regfile_in), 64'(vt[n].exp_data));
    end

    // All sources push every cycle; grants rotate and FIFOs fill to the limit.
    do_reset();
    for (int c = 0; c < 8; c++) step(3'b111, 1'b1, 1'b0);
    for (int c = 0; c < 40; c++) begin
      if (mc[0] + mc[1] + mc[2] == 0 && !e_load) break;
      step(3'b000, 1'b1, 1'b0);
    end
    chk("drain busy", 64'(busy), 64'd0);

    // Fill source 1, then flush with a concurrent push and pop request.
    do_reset();
    for (int c = 0; c < 4; c++) step(3'b010, 1'b0, 1'b0);
    step(3'b011, 1'b1, 1'b1);
    chk("post-flush busy", 64'(busy), 64'd0);
    chk("post-flush src_ready", 64'(bus.src_ready), 64'h7);
    for (int c = 0; c < 3; c++) step(3'b000, 1'b1, 1'b0);

    // Stall with two queued entries, then release for back-to-back writes.
    do_reset();
    step(3'b100, 1'b0, 1'b0);
    step(3'b100, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    chk("release first", 64'(regfile_in), 64'h0200_0000);
    step(3'b000, 1'b1, 1'b0);
    chk("release second", 64'(regfile_in), 64'h0200_0001);
    step(3'b000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
